// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between an instruction-fetch port and a load/store data port,
// sequencing one main-memory access at a time and returning results with a one-cycle ack.
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_data_out,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  state_t        state_q, state_d;
  logic          last_grant_q;
  logic          owner_q;
  logic          we_q;
  logic [2:0]    lat_q;

  logic          grant_valid;
  logic          grant_data;
  logic          sel_we;
  logic          sel_misaligned;
  logic [AW-1:0] sel_addr;

  logic          complete;
  logic          cmpl_port;
  logic          cmpl_err;
  logic [DW-1:0] cmpl_rdata;

  // A tie goes to whichever port was not granted last.
  always_comb begin
    grant_valid    = if_req | d_req;
    grant_data     = d_req & (~if_req | (last_grant_q == PORT_FETCH));
    sel_addr       = grant_data ? d_addr : if_addr;
    sel_we         = grant_data & d_we;
    sel_misaligned = (sel_addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = sel_misaligned ? DONE : ISSUE;
        end
      end
      ISSUE: state_d = we_q ? DONE : WAIT;
      WAIT: begin
        if (lat_q == 3'd1) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result for the port finishing this cycle: misaligned from IDLE, store from ISSUE, load from WAIT.
  always_comb begin
    complete   = (state_d == DONE) && (state_q != DONE);
    cmpl_port  = (state_q == IDLE) ? grant_data : owner_q;
    cmpl_err   = (state_q == IDLE);
    cmpl_rdata = (state_q == WAIT) ? mem_data_out : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PORT_FETCH;
      owner_q      <= PORT_FETCH;
      we_q         <= 1'b0;
      lat_q        <= 3'd0;
    end else begin
      if ((state_q == IDLE) && grant_valid) begin
        owner_q      <= grant_data;
        last_grant_q <= grant_data;
        we_q         <= sel_we;
      end
      if (state_q == ISSUE) begin
        lat_q <= 3'(RD_LAT);
      end else if (state_q == WAIT) begin
        lat_q <= lat_q - 3'd1;
      end
    end
  end

  // Address/data registers double as the latched request copy and hold between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_address <= '0;
      mem_data_in <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      if ((state_q == IDLE) && grant_valid && !sel_misaligned) begin
        mem_address <= sel_addr;
        mem_rd      <= ~sel_we;
        mem_wr      <= sel_we;
        if (sel_we) begin
          mem_data_in <= d_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata <= '0;
      if_err   <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else if (complete) begin
      if (cmpl_port == PORT_DATA) begin
        d_rdata <= cmpl_rdata;
        d_err   <= cmpl_err;
      end else begin
        if_rdata <= cmpl_rdata;
        if_err   <= cmpl_err;
      end
    end
  end

  assign if_ack = !rst && (state_q == DONE) && (owner_q == PORT_FETCH);
  assign d_ack  = !rst && (state_q == DONE) && (owner_q == PORT_DATA);
  assign busy   = (state_q != IDLE);

endmodule
